// File: rtl/bmem_pkg.sv
// Shared types for the burst-memory line adapter.
// Beat width, FSM states and requester selector.
package bmem_pkg;

    localparam int BEAT_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_BEATS,
        WR_BEATS,
        DONE
    } adapter_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_sel_t;

endpackage

// File: rtl/bmem_rr_arbiter2.sv
// Two-input round-robin arbiter for the i-side and d-side L2 ports.
// Ties go to the side that was not granted last; history moves on accept.
module bmem_rr_arbiter2
    import bmem_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      req_i,
    input  logic      req_d,
    input  logic      accept,
    output logic      valid,
    output port_sel_t grant
);

    port_sel_t rr_last;

    // Pick a side: lone requester wins, a tie goes opposite to rr_last
    always_comb begin
        valid = req_i | req_d;
        grant = PORT_I;
        if (req_i && req_d) begin
            if (rr_last == PORT_D) begin
                grant = PORT_I;
            end else begin
                grant = PORT_D;
            end
        end else if (req_d) begin
            grant = PORT_D;
        end
    end

    // Remember the last granted side once the grant is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= PORT_D;
        end else if (accept && valid) begin
            rr_last <= grant;
        end
    end

endmodule

// File: rtl/bmem_line_adapter.sv
// Line-to-burst adapter between the two L2 caches and the bmem port.
// Arbitrates whole-line requests, serialises writes, assembles read bursts.
module bmem_line_adapter
    import bmem_pkg::*;
#(
    parameter int CACHE_LOG2_WORDSIZE = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [31:0]                         i_addr,
    input  logic                                i_read,
    output logic [(2**CACHE_LOG2_WORDSIZE)-1:0] i_rdata,
    output logic                                i_resp,
    input  logic [31:0]                         d_addr,
    input  logic                                d_read,
    input  logic                                d_write,
    input  logic [(2**CACHE_LOG2_WORDSIZE)-1:0] d_wdata,
    output logic [(2**CACHE_LOG2_WORDSIZE)-1:0] d_rdata,
    output logic                                d_resp,
    output logic [31:0]                         bmem_address,
    output logic                                bmem_read,
    output logic                                bmem_write,
    output logic [63:0]                         bmem_wdata,
    input  logic [63:0]                         bmem_rdata,
    input  logic                                bmem_resp
);

    localparam int LINE_W    = 2 ** CACHE_LOG2_WORDSIZE;
    localparam int BURST_LEN = 2 ** (CACHE_LOG2_WORDSIZE - 6);
    localparam int CNT_W     = $clog2(BURST_LEN);
    localparam int OFF_W     = CACHE_LOG2_WORDSIZE - 3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFF_W) - 32'd1);

    adapter_state_t state;
    port_sel_t      owner;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] line;

    logic        req_valid;
    port_sel_t   grant;
    logic        accept;
    logic        grant_wr;
    logic [31:0] aligned;
    logic [LINE_W-1:0] shifted;

    assign accept = (state == IDLE);

    bmem_rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  (i_read),
        .req_d  (d_read | d_write),
        .accept (accept),
        .valid  (req_valid),
        .grant  (grant)
    );

    // Grant decode: d-side write wins over d-side read; address is line-aligned
    always_comb begin
        grant_wr = (grant == PORT_D) && d_write;
        if (grant == PORT_I) begin
            aligned = i_addr & ALIGN_MASK;
        end else begin
            aligned = d_addr & ALIGN_MASK;
        end
        shifted = {bmem_rdata, line[LINE_W-1:BEAT_W]};
    end

    // Adapter FSM; every bmem and response output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= PORT_I;
            cnt          <= '0;
            line         <= '0;
            bmem_address <= '0;
            bmem_read    <= 1'b0;
            bmem_write   <= 1'b0;
            bmem_wdata   <= '0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    i_resp  <= 1'b0;
                    d_resp  <= 1'b0;
                    i_rdata <= '0;
                    d_rdata <= '0;
                    if (req_valid) begin
                        owner        <= grant;
                        cnt          <= '0;
                        bmem_address <= aligned;
                        if (grant_wr) begin
                            line       <= d_wdata >> BEAT_W;
                            bmem_wdata <= d_wdata[BEAT_W-1:0];
                            bmem_write <= 1'b1;
                            state      <= WR_BEATS;
                        end else begin
                            bmem_read <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    bmem_read    <= 1'b0;
                    bmem_address <= '0;
                    if (bmem_resp) begin
                        line <= shifted;
                        cnt  <= cnt + 1'b1;
                    end
                    state <= RD_BEATS;
                end
                RD_BEATS: begin
                    if (bmem_resp) begin
                        line <= shifted;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= DONE;
                            if (owner == PORT_I) begin
                                i_resp  <= 1'b1;
                                i_rdata <= shifted;
                            end else begin
                                d_resp  <= 1'b1;
                                d_rdata <= shifted;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WR_BEATS: begin
                    bmem_write   <= 1'b0;
                    bmem_address <= '0;
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        bmem_wdata <= '0;
                        line       <= '0;
                        d_resp     <= 1'b1;
                        d_rdata    <= '0;
                        state      <= DONE;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        bmem_wdata <= line[BEAT_W-1:0];
                        line       <= line >> BEAT_W;
                    end
                end
                DONE: begin
                    i_resp  <= 1'b0;
                    d_resp  <= 1'b0;
                    i_rdata <= '0;
                    d_rdata <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed testbench for bmem_line_adapter (LINE_W=1024, 16 beats).
// Acts as both L2 requesters and as the burst memory responder.
module tb_bmem_line_adapter;

    localparam int LW = 1024;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   i_addr;
    logic          i_read;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic [31:0]   d_addr;
    logic          d_read;
    logic          d_write;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic [31:0]   bmem_address;
    logic          bmem_read;
    logic          bmem_write;
    logic [63:0]   bmem_wdata;
    logic [63:0]   bmem_rdata;
    logic          bmem_resp;

    int checks = 0;
    int errors = 0;
    int n_rd_cmd = 0;
    int n_both = 0;

    always #5 clk = ~clk;

    bmem_line_adapter #(.CACHE_LOG2_WORDSIZE(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (i_addr),
        .i_read       (i_read),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_addr       (d_addr),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .bmem_address (bmem_address),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp)
    );

    // Count read commands and any read/write overlap
    always @(posedge clk) begin
        if (bmem_read === 1'b1) n_rd_cmd++;
        if (bmem_read === 1'b1 && bmem_write === 1'b1) n_both++;
    end

    function automatic logic [LW-1:0] read_line(input logic [63:0] base);
        logic [LW-1:0] l;
        l = '0;
        for (int k = 0; k < BL; k++) l[64*k +: 64] = base + 64'(k);
        return l;
    endfunction

    function automatic logic [LW-1:0] wr_line(input logic [31:0] tag);
        logic [LW-1:0] l;
        l = '0;
        for (int j = 0; j < 32; j++) l[32*j +: 32] = tag | 32'(j);
        return l;
    endfunction

    function automatic int first_bad(input logic [LW-1:0] a, input logic [LW-1:0] b);
        for (int k = 0; k < BL; k++) if (a[64*k +: 64] !== b[64*k +: 64]) return k;
        return 0;
    endfunction

    // Memory responder: waits for bmem_read, then returns 16 beats (beat 0 in the
    // command cycle), with optional idle gap after beat gap_after.
    // Returns at the negedge of the cycle after the last beat.
    task automatic serve_read(input logic [63:0] base, input int gap_after,
                              input int gap_len, output logic [31:0] addr,
                              output bit ok);
        ok = 1'b0;
        addr = '0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (bmem_read === 1'b1) ok = 1'b1;
        end
        if (!ok) return;
        addr = bmem_address;
        for (int k = 0; k < BL; k++) begin
            bmem_resp = 1'b1;
            bmem_rdata = base + 64'(k);
            @(negedge clk);
            bmem_resp = 1'b0;
            bmem_rdata = '0;
            if (k == gap_after) repeat (gap_len) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bmem_read, bmem_write, i_resp, d_resp} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000", {bmem_read, bmem_write, i_resp, d_resp});
        end
        checks++;
        if (bmem_address !== 32'h0 || bmem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h wdata=%h want 0", bmem_address, bmem_wdata);
        end
        checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata got nonzero want 0");
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        logic [31:0] addr;
        bit ok;
        int rd0;
        logic [LW-1:0] want;
        int b;
        want = read_line(64'h1111_0000_0000_0000);
        rd0 = n_rd_cmd;
        i_addr = 32'h0000_1044;
        i_read = 1'b1;
        serve_read(64'h1111_0000_0000_0000, -1, 0, addr, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rd1_timeout got no bmem_read want bmem_read");
        end
        checks++;
        if (addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL rd1_addr got %h want 00001000", addr);
        end
        checks++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
            errors++;
            $display("FAIL rd1_resp got i=%b d=%b want i=1 d=0", i_resp, d_resp);
        end
        checks++;
        if (i_rdata !== want) begin
            errors++;
            b = first_bad(i_rdata, want);
            $display("FAIL rd1_line beat %0d got %h want %h", b, i_rdata[64*b +: 64], want[64*b +: 64]);
        end
        i_read = 1'b0;
        @(negedge clk);
        checks++;
        if (i_resp !== 1'b0 || i_rdata !== '0) begin
            errors++;
            $display("FAIL rd1_pulse got i_resp=%b want 0", i_resp);
        end
        checks++;
        if (n_rd_cmd - rd0 !== 1) begin
            errors++;
            $display("FAIL rd1_cmds got %0d want 1", n_rd_cmd - rd0);
        end
    endtask

    task automatic test_write();
        bit found;
        int lat;
        int bad_ctl;
        logic [63:0] wb;
        found = 1'b0;
        lat = 0;
        bad_ctl = 0;
        d_wdata = wr_line(32'h0);
        d_addr = 32'h8000_0080;
        d_write = 1'b1;
        for (int t = 1; t <= 20 && !found; t++) begin
            @(negedge clk);
            if (bmem_write === 1'b1) begin
                found = 1'b1;
                lat = t;
            end
        end
        checks++;
        if (!found || lat != 1) begin
            errors++;
            $display("FAIL wr_start got found=%0d lat=%0d want found=1 lat=1", found, lat);
        end
        checks++;
        if (bmem_address !== 32'h8000_0080) begin
            errors++;
            $display("FAIL wr_addr got %h want 80000080", bmem_address);
        end
        for (int k = 0; k < BL; k++) begin
            wb = {32'(2 * k + 1), 32'(2 * k)};
            checks++;
            if (bmem_wdata !== wb) begin
                errors++;
                $display("FAIL wr_beat%0d got %h want %h", k, bmem_wdata, wb);
            end
            if (bmem_write !== (k == 0) || bmem_read !== 1'b0 || d_resp !== 1'b0) bad_ctl++;
            @(negedge clk);
        end
        checks++;
        if (bad_ctl != 0) begin
            errors++;
            $display("FAIL wr_ctl got %0d bad beats want 0", bad_ctl);
        end
        checks++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL wr_done got d=%b i=%b want d=1 i=0", d_resp, i_resp);
        end
        d_write = 1'b0;
        @(negedge clk);
        checks++;
        if (d_resp !== 1'b0) begin
            errors++;
            $display("FAIL wr_pulse got %b want 0", d_resp);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] addr;
        bit ok;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        i_addr = 32'h0000_3000;
        d_addr = 32'h0000_2000;
        i_read = 1'b1;
        d_read = 1'b1;
        serve_read(64'hAAAA_0000_0000_0000, -1, 0, addr, ok);
        checks++;
        if (!ok || addr !== 32'h0000_3000 || i_resp !== 1'b1 || d_resp !== 1'b0) begin
            errors++;
            $display("FAIL arb_first got ok=%0d addr=%h i=%b d=%b want addr=00003000 i=1", ok, addr, i_resp, d_resp);
        end
        checks++;
        if (i_rdata !== read_line(64'hAAAA_0000_0000_0000)) begin
            errors++;
            $display("FAIL arb_first_line got bad line want AAAA beats");
        end
        i_read = 1'b0;
        @(negedge clk);
        i_addr = 32'h0000_4010;
        i_read = 1'b1;
        serve_read(64'hBBBB_0000_0000_0000, -1, 0, addr, ok);
        checks++;
        if (!ok || addr !== 32'h0000_2000 || d_resp !== 1'b1 || i_resp !== 1'b0) begin
            errors++;
            $display("FAIL arb_second got ok=%0d addr=%h i=%b d=%b want addr=00002000 d=1", ok, addr, i_resp, d_resp);
        end
        checks++;
        if (d_rdata !== read_line(64'hBBBB_0000_0000_0000)) begin
            errors++;
            $display("FAIL arb_second_line got bad line want BBBB beats");
        end
        d_read = 1'b0;
        serve_read(64'hCCCC_0000_0000_0000, -1, 0, addr, ok);
        checks++;
        if (!ok || addr !== 32'h0000_4000 || i_resp !== 1'b1 || i_rdata !== read_line(64'hCCCC_0000_0000_0000)) begin
            errors++;
            $display("FAIL arb_third got ok=%0d addr=%h i=%b want addr=00004000 i=1", ok, addr, i_resp);
        end
        i_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_gap();
        logic [31:0] addr;
        bit ok;
        logic [LW-1:0] want;
        int b;
        want = read_line(64'h3333_0000_0000_0000);
        i_addr = 32'h0000_7000;
        i_read = 1'b1;
        serve_read(64'h3333_0000_0000_0000, 5, 3, addr, ok);
        checks++;
        if (!ok || addr !== 32'h0000_7000 || i_resp !== 1'b1) begin
            errors++;
            $display("FAIL gap_resp got ok=%0d addr=%h i=%b want addr=00007000 i=1", ok, addr, i_resp);
        end
        checks++;
        if (i_rdata !== want) begin
            errors++;
            b = first_bad(i_rdata, want);
            $display("FAIL gap_line beat %0d got %h want %h", b, i_rdata[64*b +: 64], want[64*b +: 64]);
        end
        i_read = 1'b0;
        @(negedge clk);
        checks++;
        if (i_resp !== 1'b0 || bmem_read !== 1'b0) begin
            errors++;
            $display("FAIL gap_after got i=%b rd=%b want 0 0", i_resp, bmem_read);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] addr;
        bit ok;
        int bad;
        int rd0;
        logic [LW-1:0] want;
        ok = 1'b0;
        bad = 0;
        d_addr = 32'h0000_5000;
        d_read = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (bmem_read === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_timeout got no bmem_read want bmem_read");
        end
        for (int k = 0; k < 8; k++) begin
            bmem_resp = 1'b1;
            bmem_rdata = 64'h5555_0000_0000_0000 + 64'(k);
            @(negedge clk);
        end
        rst = 1'b1;
        d_read = 1'b0;
        bmem_rdata = 64'h5555_0000_0000_0008;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bmem_read, bmem_write, i_resp, d_resp} !== 4'b0000 || d_rdata !== '0) begin
            errors++;
            $display("FAIL abort_outs got %b want 0000", {bmem_read, bmem_write, i_resp, d_resp});
        end
        rd0 = n_rd_cmd;
        for (int k = 9; k < BL; k++) begin
            bmem_resp = 1'b1;
            bmem_rdata = 64'h5555_0000_0000_0000 + 64'(k);
            @(negedge clk);
            if (d_resp !== 1'b0 || i_resp !== 1'b0) bad++;
        end
        bmem_resp = 1'b0;
        bmem_rdata = '0;
        checks++;
        if (bad != 0 || n_rd_cmd != rd0) begin
            errors++;
            $display("FAIL abort_late got %0d resp cycles %0d cmds want 0 0", bad, n_rd_cmd - rd0);
        end
        want = read_line(64'h2222_0000_0000_0000);
        i_addr = 32'h0000_6000;
        i_read = 1'b1;
        serve_read(64'h2222_0000_0000_0000, -1, 0, addr, ok);
        checks++;
        if (!ok || addr !== 32'h0000_6000 || i_resp !== 1'b1 || d_resp !== 1'b0) begin
            errors++;
            $display("FAIL abort_next got ok=%0d addr=%h i=%b d=%b want addr=00006000 i=1", ok, addr, i_resp, d_resp);
        end
        checks++;
        if (i_rdata !== want) begin
            errors++;
            $display("FAIL abort_line got %h want %h", i_rdata[63:0], want[63:0]);
        end
        i_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rw_both();
        bit found;
        int rd0;
        logic [LW-1:0] wl;
        found = 1'b0;
        rd0 = n_rd_cmd;
        wl = wr_line(32'hA500_0000);
        d_wdata = wl;
        d_addr = 32'h0000_0040;
        d_read = 1'b1;
        d_write = 1'b1;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (bmem_write === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || bmem_address !== 32'h0) begin
            errors++;
            $display("FAIL rw_start got found=%0d addr=%h want 1 00000000", found, bmem_address);
        end
        for (int k = 0; k < BL; k++) begin
            if (k == 0 || k == 9) begin
                checks++;
                if (bmem_wdata !== {32'hA500_0000 | 32'(2 * k + 1), 32'hA500_0000 | 32'(2 * k)}) begin
                    errors++;
                    $display("FAIL rw_beat%0d got %h", k, bmem_wdata);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (d_resp !== 1'b1) begin
            errors++;
            $display("FAIL rw_resp got %b want 1", d_resp);
        end
        d_read = 1'b0;
        d_write = 1'b0;
        @(negedge clk);
        checks++;
        if (n_rd_cmd != rd0) begin
            errors++;
            $display("FAIL rw_noread got %0d want 0", n_rd_cmd - rd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_addr = '0;
        i_read = 1'b0;
        d_addr = '0;
        d_read = 1'b0;
        d_write = 1'b0;
        d_wdata = '0;
        bmem_rdata = '0;
        bmem_resp = 1'b0;
        test_reset();
        test_single_read();
        test_write();
        test_arbitration();
        test_gap();
        test_reset_abort();
        test_rw_both();
        checks++;
        if (n_both != 0) begin
            errors++;
            $display("FAIL rw_overlap got %0d want 0", n_both);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
